// File: rtl/divider_pkg.sv
// Shared definitions for the sequential restoring divider.
//   state_t        : divider FSM states
//   DEFAULT_WIDTH  : default operand/result width
//   cnt_width()    : step-counter width for a given operand width
package divider_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  localparam int unsigned DEFAULT_WIDTH = 4;

  function automatic int unsigned cnt_width(input int unsigned width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/divider_step.sv
// One combinational restoring-division step.
//   rem      : current partial remainder R (WIDTH+1 bits)
//   q_msb    : quotient/dividend shift-register MSB shifted into R
//   div      : divisor D
//   rem_next : partial remainder after the trial subtraction
//   q_bit    : quotient bit produced by this step
module divider_step #(
  parameter int unsigned WIDTH = 4
) (
  input  logic [WIDTH:0]   rem,
  input  logic             q_msb,
  input  logic [WIDTH-1:0] div,
  output logic [WIDTH:0]   rem_next,
  output logic             q_bit
);

  logic [WIDTH:0]   trial;
  logic [WIDTH+1:0] diff;
  // R's top bit is always 0 between steps; only the low WIDTH bits shift up.
  logic             unused_rem_msb;

  assign unused_rem_msb = rem[WIDTH];

  always_comb begin
    trial    = {rem[WIDTH-1:0], q_msb};
    // Extra top bit of the difference is the borrow-out: set when trial < D.
    diff     = {1'b0, trial} - {2'b00, div};
    q_bit    = ~diff[WIDTH+1];
    rem_next = q_bit ? diff[WIDTH:0] : trial;
  end

endmodule

// File: rtl/seq_divider.sv
// Iterative restoring unsigned divider, one quotient bit per cycle.
//   clock, reset      : rising-edge clock, async active-low reset
//   io_in_valid/ready : operand handshake (io_dividend, io_divisor)
//   io_out_valid/ready: result handshake (io_quotient, io_remainder,
//                       io_divByZero)
// A zero divisor yields quotient all-ones and remainder = dividend.
module seq_divider
  import divider_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             io_in_valid,
  output logic             io_in_ready,
  input  logic [WIDTH-1:0] io_dividend,
  input  logic [WIDTH-1:0] io_divisor,
  output logic             io_out_valid,
  input  logic             io_out_ready,
  output logic [WIDTH-1:0] io_quotient,
  output logic [WIDTH-1:0] io_remainder,
  output logic             io_divByZero
);

  localparam int unsigned CW = cnt_width(WIDTH);

  state_t           state;
  logic [WIDTH-1:0] q_reg;
  logic [WIDTH-1:0] d_reg;
  logic [WIDTH:0]   r_reg;
  logic             dz_reg;
  logic [CW-1:0]    step_cnt;
  logic [WIDTH:0]   r_next;
  logic             q_bit;

  divider_step #(.WIDTH(WIDTH)) u_step (
    .rem      (r_reg),
    .q_msb    (q_reg[WIDTH-1]),
    .div      (d_reg),
    .rem_next (r_next),
    .q_bit    (q_bit)
  );

  assign io_in_ready = (state == IDLE);

  // Result outputs are a separate register stage loaded on the first DONE
  // cycle, so io_out_valid rises one edge after the FSM reaches DONE and
  // never exposes in-flight Q/R contents.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      q_reg        <= '0;
      d_reg        <= '0;
      r_reg        <= '0;
      dz_reg       <= 1'b0;
      step_cnt     <= '0;
      io_out_valid <= 1'b0;
      io_quotient  <= '0;
      io_remainder <= '0;
      io_divByZero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (io_in_valid) begin
            d_reg    <= io_divisor;
            step_cnt <= '0;
            if (io_divisor == '0) begin
              dz_reg <= 1'b1;
              q_reg  <= '1;
              r_reg  <= {1'b0, io_dividend};
              state  <= DONE;
            end else begin
              q_reg <= io_dividend;
              r_reg <= '0;
              state <= BUSY;
            end
          end
        end
        BUSY: begin
          r_reg    <= r_next;
          q_reg    <= {q_reg[WIDTH-2:0], q_bit};
          step_cnt <= step_cnt + CW'(1);
          if (step_cnt == CW'(WIDTH - 1)) state <= DONE;
        end
        DONE: begin
          if (!io_out_valid) begin
            io_out_valid <= 1'b1;
            io_quotient  <= q_reg;
            io_remainder <= r_reg[WIDTH-1:0];
            io_divByZero <= dz_reg;
          end else if (io_out_ready) begin
            io_out_valid <= 1'b0;
            dz_reg       <= 1'b0;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider at WIDTH=4 using a result scoreboard.
module tb_seq_divider;

  localparam int unsigned W = 4;

  typedef struct {
    int n;
    int d;
    int q;
    int r;
    int dz;
  } res_t;

  logic         clock;
  logic         reset;
  logic         io_in_valid;
  logic         io_in_ready;
  logic [W-1:0] io_dividend;
  logic [W-1:0] io_divisor;
  logic         io_out_valid;
  logic         io_out_ready;
  logic [W-1:0] io_quotient;
  logic [W-1:0] io_remainder;
  logic         io_divByZero;

  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   acc_cyc = 0;
  int   xfer_cyc = 0;
  res_t sb[$];

  seq_divider #(.WIDTH(W)) dut (
    .clock        (clock),
    .reset        (reset),
    .io_in_valid  (io_in_valid),
    .io_in_ready  (io_in_ready),
    .io_dividend  (io_dividend),
    .io_divisor   (io_divisor),
    .io_out_valid (io_out_valid),
    .io_out_ready (io_out_ready),
    .io_quotient  (io_quotient),
    .io_remainder (io_remainder),
    .io_divByZero (io_divByZero)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic res_t model(input int n, input int d);
    res_t e;
    e.n = n;
    e.d = d;
    if (d == 0) begin
      e.q  = (1 << W) - 1;
      e.r  = n;
      e.dz = 1;
    end else begin
      e.q  = n / d;
      e.r  = n % d;
      e.dz = 0;
    end
    return e;
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Called #1 after an edge; returns #1 after the accepting edge.
  task automatic issue(input int n, input int d);
    int waited = 0;
    while (!io_in_ready && waited < 50) begin
      step();
      waited++;
    end
    check("in_ready_before_issue", io_in_ready, 1);
    io_dividend = W'(n);
    io_divisor  = W'(d);
    io_in_valid = 1'b1;
    sb.push_back(model(n, d));
    step();
    acc_cyc     = cyc;
    io_in_valid = 1'b0;
  endtask

  // Waits for a result, optionally stalls it for 'hold' cycles, then drains it.
  task automatic collect(input int hold, input int exp_lat);
    int   waited = 0;
    int   stable_ok = 1;
    res_t e;
    io_out_ready = (hold == 0);
    while (!io_out_valid && waited < 50) begin
      step();
      waited++;
    end
    check("out_valid_rise", io_out_valid, 1);
    if (!io_out_valid) return;
    if (exp_lat >= 0) check("latency", cyc - acc_cyc, exp_lat);
    if (sb.size() == 0) begin
      check("scoreboard_nonempty", 0, 1);
      return;
    end
    e = sb.pop_front();
    for (int i = 0; i < hold; i++) begin
      step();
      if (!io_out_valid || io_in_ready || io_quotient !== W'(e.q) ||
          io_remainder !== W'(e.r) || io_divByZero !== e.dz[0])
        stable_ok = 0;
    end
    if (hold > 0) check("hold_stable", stable_ok, 1);
    check("quotient", io_quotient, e.q);
    check("remainder", io_remainder, e.r);
    check("div_by_zero", io_divByZero, e.dz);
    if (e.d != 0) begin
      check("identity", int'(io_quotient) * e.d + int'(io_remainder), e.n);
      check("rem_lt_div", int'(io_remainder < W'(e.d)), 1);
    end
    io_out_ready = 1'b1;
    step();
    xfer_cyc = cyc;
    check("out_valid_drop", io_out_valid, 0);
  endtask

  initial begin
    reset        = 1'b0;
    io_in_valid  = 1'b0;
    io_dividend  = '0;
    io_divisor   = '0;
    io_out_ready = 1'b0;
    step();
    step();
    check("rst_in_ready", io_in_ready, 1);
    check("rst_out_valid", io_out_valid, 0);
    check("rst_quotient", io_quotient, 0);
    check("rst_remainder", io_remainder, 0);
    check("rst_div_by_zero", io_divByZero, 0);
    reset = 1'b1;
    step();

    // 13 / 3, consumer always ready
    io_out_ready = 1'b1;
    issue(13, 3);
    check("busy_in_ready", io_in_ready, 0);
    collect(0, 5);

    // 15 / 1 then 2 / 9 back-to-back
    issue(15, 1);
    collect(0, 5);
    issue(2, 9);
    check("b2b_accept_gap", acc_cyc - xfer_cyc, 1);
    collect(0, 5);

    // zero divisor, then a normal request
    issue(7, 0);
    collect(0, 1);
    issue(8, 2);
    collect(0, 5);

    // backpressure for 10 cycles
    issue(14, 5);
    collect(10, 5);
    step();
    check("single_transfer", io_out_valid, 0);

    // asynchronous reset in the middle of BUSY step 2
    issue(9, 2);
    step();
    check("pre_reset_busy", io_in_ready, 0);
    #2;
    reset = 1'b0;
    #1;
    check("mid_rst_out_valid", io_out_valid, 0);
    check("mid_rst_in_ready", io_in_ready, 1);
    check("mid_rst_quotient", io_quotient, 0);
    check("mid_rst_remainder", io_remainder, 0);
    check("mid_rst_div_by_zero", io_divByZero, 0);
    sb.delete();
    reset = 1'b1;
    step();
    issue(9, 2);
    collect(0, 5);

    // exhaustive sweep
    for (int n = 0; n < (1 << W); n++) begin
      for (int d = 0; d < (1 << W); d++) begin
        issue(n, d);
        collect(0, (d == 0) ? 1 : 5);
      end
    end

    check("scoreboard_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
